// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions for the IF/ID, ID/EX and EX/MEM registers.
package pipe_pkg;

    // Occupancy of a two-slot (main + skid) stage register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    // All-zero encoding is the architectural NOP for the 20-bit ISA.
    localparam logic [19:0] NOP_INSTR_DEFAULT = 20'b0;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: an instruction plus NUM_OPS operands.
// clear wins over load and returns the slot to the NOP bubble.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 20,
    parameter int                 DATA_W    = 20,
    parameter int                 NUM_OPS   = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      clear,
    input  logic [INSTR_W-1:0]        next_instruction,
    input  logic [NUM_OPS*DATA_W-1:0] next_operands,
    output logic [INSTR_W-1:0]        instruction,
    output logic [NUM_OPS*DATA_W-1:0] operands
);

    // Slot register: reset/clear to NOP bubble, otherwise load when asked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_INSTR;
            operands    <= '0;
        end else if (clear) begin
            instruction <= NOP_INSTR;
            operands    <= '0;
        end else if (load) begin
            instruction <= next_instruction;
            operands    <= next_operands;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX stage register with valid/ready handshake, skid slot, flush and
// saturating back-pressure counter.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | main slot holds a NOP bubble, out_valid = 0
//   ST_FULL  | main slot valid, skid slot empty
//   ST_SKID  | main and skid both valid, in_ready = 0
//
// in_ready and out_valid decode the registered state only, so there is no
// combinational path from out_ready to in_ready.
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 20,
    parameter int                 DATA_W    = 20,
    parameter int                 NUM_OPS   = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
    parameter int                 STALL_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_W-1:0]        in_instruction,
    input  logic [NUM_OPS*DATA_W-1:0] in_operands,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_W-1:0]        out_instruction,
    output logic [NUM_OPS*DATA_W-1:0] out_operands,
    output logic [STALL_W-1:0]        stall_count
);

    localparam int OPS_W = NUM_OPS * DATA_W;

    stage_state_t       state;
    stage_state_t       state_next;
    logic               accept;
    logic               drain;
    logic               stall;
    logic               main_load;
    logic               main_clear;
    logic               main_from_skid;
    logic               skid_load;
    logic               skid_clear;
    logic [INSTR_W-1:0] skid_instruction;
    logic [OPS_W-1:0]   skid_operands;
    logic [INSTR_W-1:0] main_next_instruction;
    logic [OPS_W-1:0]   main_next_operands;

    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign stall     = out_valid & ~out_ready;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides every handshake event.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_next = ST_FULL;
                ST_FULL: begin
                    if (accept && !drain)      state_next = ST_SKID;
                    else if (!accept && drain) state_next = ST_EMPTY;
                end
                ST_SKID:  if (drain) state_next = ST_FULL;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Slot control decode for the current state and handshake.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = flush;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = flush;
        if (!flush) begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_FULL: begin
                    if (accept && drain)       main_load  = 1'b1;
                    else if (accept && !drain) skid_load  = 1'b1;
                    else if (!accept && drain) main_clear = 1'b1;
                end
                ST_SKID: begin
                    // Skid is returned to a bubble once promoted so an empty
                    // skid never carries a stale word.
                    if (drain) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: main_clear = 1'b1;
            endcase
        end
    end

    assign main_next_instruction = main_from_skid ? skid_instruction : in_instruction;
    assign main_next_operands    = main_from_skid ? skid_operands    : in_operands;

    pipe_slot #(
        .INSTR_W   (INSTR_W),
        .DATA_W    (DATA_W),
        .NUM_OPS   (NUM_OPS),
        .NOP_INSTR (NOP_INSTR)
    ) u_main_slot (
        .clock            (clock),
        .reset            (reset),
        .load             (main_load),
        .clear            (main_clear),
        .next_instruction (main_next_instruction),
        .next_operands    (main_next_operands),
        .instruction      (out_instruction),
        .operands         (out_operands)
    );

    pipe_slot #(
        .INSTR_W   (INSTR_W),
        .DATA_W    (DATA_W),
        .NUM_OPS   (NUM_OPS),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid_slot (
        .clock            (clock),
        .reset            (reset),
        .load             (skid_load),
        .clear            (skid_clear),
        .next_instruction (in_instruction),
        .next_operands    (in_operands),
        .instruction      (skid_instruction),
        .operands         (skid_operands)
    );

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: a default-parameter instance for the
// handshake/flush behaviour and a wide, short-counter instance for operand
// packing and saturation.
module tb_id_ex_stage_reg;

    logic        clock;
    logic        reset;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_instruction;
    logic [39:0] in_operands;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_instruction;
    logic [39:0] out_operands;
    logic [15:0] stall_count;

    logic        flush2;
    logic        in_valid2;
    logic        in_ready2;
    logic [19:0] in_instruction2;
    logic [95:0] in_operands2;
    logic        out_valid2;
    logic        out_ready2;
    logic [19:0] out_instruction2;
    logic [95:0] out_operands2;
    logic [3:0]  stall_count2;

    int tests_run;
    int tests_failed;

    localparam logic [39:0] OPS_A = {20'h00022, 20'h00011};

    id_ex_stage_reg dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_operands     (in_operands),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_operands    (out_operands),
        .stall_count     (stall_count)
    );

    id_ex_stage_reg #(
        .DATA_W  (32),
        .NUM_OPS (3),
        .STALL_W (4)
    ) dut_wide (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush2),
        .in_valid        (in_valid2),
        .in_ready        (in_ready2),
        .in_instruction  (in_instruction2),
        .in_operands     (in_operands2),
        .out_valid       (out_valid2),
        .out_ready       (out_ready2),
        .out_instruction (out_instruction2),
        .out_operands    (out_operands2),
        .stall_count     (stall_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_instruction = 20'h00007; in_operands = OPS_A; out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_valid: got %0b want 1", out_valid); end
        tests_run++;
        if (stall_count !== 16'd1) begin tests_failed++; $display("FAIL pre_reset_stall: got %0d want 1", stall_count); end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tests_run++;
        if (out_instruction !== 20'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want 00000", out_instruction); end
        tests_run++;
        if (out_operands !== 40'h0) begin tests_failed++; $display("FAIL reset_operands: got %h want 0", out_operands); end
        tests_run++;
        if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
        tests_run++;
        if (out_valid2 !== 1'b0 || stall_count2 !== 4'd0) begin
            tests_failed++; $display("FAIL reset_wide: valid %0b stall %0d want 0 0", out_valid2, stall_count2);
        end
        #2 reset = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_operands = OPS_A;
        for (int i = 1; i <= 5; i++) begin
            in_instruction = 20'(i);
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_instruction !== 20'(i) || out_operands !== OPS_A) begin
                tests_failed++;
                $display("FAIL stream_word%0d: got v=%0b i=%h o=%h want v=1 i=%h o=%h",
                         i, out_valid, out_instruction, out_operands, 20'(i), OPS_A);
            end
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_ready%0d: got %0b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_instruction !== 20'h0 || out_operands !== 40'h0) begin
            tests_failed++;
            $display("FAIL stream_drain_bubble: got v=%0b i=%h o=%h want 0 00000 0", out_valid, out_instruction, out_operands);
        end
        tests_run++;
        if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL stream_stall: got %0d want 0", stall_count); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b1; in_valid = 1'b1; in_instruction = 20'h0000A; in_operands = 40'h000AA_000A1;
        tick();
        tests_run++;
        if (out_instruction !== 20'h0000A) begin tests_failed++; $display("FAIL bp_a_loaded: got %h want 0000A", out_instruction); end
        out_ready = 1'b0; in_instruction = 20'h0000B; in_operands = 40'h000BB_000B1;
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: got %0b want 0", in_ready); end
        tests_run++;
        if (out_valid !== 1'b1 || out_instruction !== 20'h0000A) begin
            tests_failed++; $display("FAIL bp_hold_a: got v=%0b i=%h want 1 0000A", out_valid, out_instruction);
        end
        in_instruction = 20'h0000C; in_operands = 40'h000CC_000C1;
        tick();
        tick();
        tests_run++;
        if (out_instruction !== 20'h0000A || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_still_a: got i=%h r=%0b want 0000A 0", out_instruction, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_instruction !== 20'h0000B || out_operands !== 40'h000BB_000B1 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_order_b: got i=%h o=%h r=%0b want 0000B 000BB000B1 1", out_instruction, out_operands, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_instruction !== 20'h0000C || out_operands !== 40'h000CC_000C1) begin
            tests_failed++; $display("FAIL bp_order_c: got v=%0b i=%h o=%h want 1 0000C 000CC000C1", out_valid, out_instruction, out_operands);
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
        tests_run++;
        if (stall_count !== 16'd3) begin tests_failed++; $display("FAIL bp_stall_count: got %0d want 3", stall_count); end
    endtask

    task automatic test_flush_skid();
        out_ready = 1'b1; in_valid = 1'b1; in_instruction = 20'h0000E; in_operands = OPS_A;
        tick();
        out_ready = 1'b0; in_instruction = 20'h0000F;
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_setup_skid: got ready %0b want 0", in_ready); end
        flush = 1'b1; in_instruction = 20'h0000D; in_operands = 40'h000DD_000D1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_instruction !== 20'h0 || out_operands !== 40'h0) begin
            tests_failed++; $display("FAIL flush_bubble: got v=%0b i=%h o=%h want 0 00000 0", out_valid, out_instruction, out_operands);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %0b want 1", in_ready); end
        tests_run++;
        if (stall_count !== 16'd5) begin tests_failed++; $display("FAIL flush_stall: got %0d want 5", stall_count); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_d%0d: got v=%0b i=%h want v=0", i, out_valid, out_instruction); end
        end
        in_valid = 1'b1; in_instruction = 20'h00061; in_operands = OPS_A;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_instruction !== 20'h00061) begin
            tests_failed++; $display("FAIL flush_after_g: got v=%0b i=%h want 1 00061", out_valid, out_instruction);
        end
        out_ready = 1'b0; in_instruction = 20'h00062;
        tick();
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_instruction !== 20'h00062 || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL flush_skid_reuse: got v=%0b i=%h want 1 00062", out_valid, out_instruction);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || stall_count !== 16'd6) begin
            tests_failed++; $display("FAIL flush_final: got v=%0b stall=%0d want 0 6", out_valid, stall_count);
        end
    endtask

    task automatic test_wide_saturation();
        out_ready2 = 1'b1; in_valid2 = 1'b1; in_instruction2 = 20'h00005;
        in_operands2 = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
        tick();
        tests_run++;
        if (out_operands2[95:64] !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL wide_op2: got %h want deadbeef", out_operands2[95:64]);
        end
        tests_run++;
        if (out_operands2[63:0] !== 64'h22222222_11111111 || out_instruction2 !== 20'h00005) begin
            tests_failed++; $display("FAIL wide_op01: got %h i=%h want 2222222211111111 00005", out_operands2[63:0], out_instruction2);
        end
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            tests_run++;
            if (stall_count2 !== ((i > 15) ? 4'd15 : 4'(i))) begin
                tests_failed++; $display("FAIL sat_cycle%0d: got %0d want %0d", i, stall_count2, (i > 15) ? 15 : i);
            end
        end
        tests_run++;
        if (out_valid2 !== 1'b1 || out_instruction2 !== 20'h00005) begin
            tests_failed++; $display("FAIL sat_hold_word: got v=%0b i=%h want 1 00005", out_valid2, out_instruction2);
        end
        out_ready2 = 1'b1;
        tick();
        tests_run++;
        if (out_valid2 !== 1'b0 || stall_count2 !== 4'hF) begin
            tests_failed++; $display("FAIL sat_after_drain: got v=%0b stall=%0d want 0 15", out_valid2, stall_count2);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instruction = '0; in_operands = '0;
        flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        in_instruction2 = '0; in_operands2 = '0;
        #12 reset = 1'b1;
        tick();
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_skid();
        test_wide_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
